// File: rtl/boot_reset_ctrl.sv
// ============================================================================
// boot_reset_ctrl: CPU boot/reset sequencer (quiesce, hold in reset, release
// with a latched boot vector). Optional DRAIN stage: BOOT_RESET_DRAIN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module boot_reset_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [7:0]  ibase_i,
  input  logic        idle_i,
  output logic        quiesce_o,
  output logic        cpu_rst_o,
  output logic [15:0] boot_adr_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);
  localparam logic [7:0] IBASE_INIT = 8'h01;

`ifdef BOOT_RESET_DRAIN_EN
  localparam state_t     REQ_TARGET = DRAIN;
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_TIMEOUT - 1);
`else
  localparam state_t     REQ_TARGET = HOLD;
  logic idle_unused;
  assign idle_unused = idle_i;
`endif

  state_t     state, state_nxt;
  logic [7:0] count, count_nxt;
  logic [7:0] ibase_q, ibase_nxt;
  logic       quiesce_nxt, cpu_rst_nxt, busy_nxt, done_nxt;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ibase_nxt = ibase_q;
    case (state)
      IDLE: begin
        count_nxt = 8'd0;
        if (req_i) begin
          ibase_nxt = ibase_i;
          state_nxt = REQ_TARGET;
        end
      end
`ifdef BOOT_RESET_DRAIN_EN
      DRAIN: begin
        // A request here only refreshes the vector; the drain timer keeps running.
        if (req_i) ibase_nxt = ibase_i;
        if (idle_i || count == DRAIN_LAST) begin
          state_nxt = HOLD;
          count_nxt = 8'd0;
        end else begin
          count_nxt = count + 8'd1;
        end
      end
`endif
      HOLD: begin
        if (req_i) begin
          ibase_nxt = ibase_i;
          count_nxt = 8'd0;
        end else if (count == RST_LAST) begin
          state_nxt = RELEASE;
          count_nxt = 8'd0;
        end else begin
          count_nxt = count + 8'd1;
        end
      end
      RELEASE: begin
        count_nxt = 8'd0;
        if (req_i) begin
          ibase_nxt = ibase_i;
          state_nxt = REQ_TARGET;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    cpu_rst_nxt = (state_nxt == HOLD);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == RELEASE);
`ifdef BOOT_RESET_DRAIN_EN
    quiesce_nxt = (state_nxt == HOLD) || (state_nxt == DRAIN);
`else
    quiesce_nxt = (state_nxt == HOLD);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= HOLD;
      count     <= 8'd0;
      ibase_q   <= IBASE_INIT;
      cpu_rst_o <= 1'b1;
      quiesce_o <= 1'b0;
      busy_o    <= 1'b1;
      done_o    <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      ibase_q   <= ibase_nxt;
      cpu_rst_o <= cpu_rst_nxt;
      quiesce_o <= quiesce_nxt;
      busy_o    <= busy_nxt;
      done_o    <= done_nxt;
    end
  end

  assign boot_adr_o = {ibase_q, 8'h00};

endmodule

`default_nettype wire

// File: tb/tb_boot_reset_ctrl.sv
// ============================================================================
// tb_boot_reset_ctrl: directed self-checking bench for boot_reset_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_boot_reset_ctrl;

  localparam int RST_CYCLES    = 16;
  localparam int DRAIN_TIMEOUT = 8;
`ifdef BOOT_RESET_DRAIN_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam int BOUND = 400;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        req   = 1'b0;
  logic        idle  = 1'b0;
  logic [7:0]  ibase = 8'h00;
  logic        quiesce, cpu_rst, busy, done;
  logic [15:0] boot_adr;

  int n_checks = 0;
  int n_fail   = 0;
  int n, rc, qc, dc;

  boot_reset_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .ibase_i   (ibase),
    .idle_i    (idle),
    .quiesce_o (quiesce),
    .cpu_rst_o (cpu_rst),
    .boot_adr_o(boot_adr),
    .busy_o    (busy),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [7:0] base, input logic idle_v);
    ibase = base;
    idle  = idle_v;
    req   = 1'b1;
    tick;
    req   = 1'b0;
  endtask

  // Runs edges until done_o, tallying cpu_rst/quiesce/drain samples including
  // the current one; optionally injects a request before edge number inject_at.
  task automatic run(input int inject_at, input logic [7:0] inj_base, input bit toggle,
                     output int cnt, output int r_cnt, output int q_cnt, output int d_cnt);
    r_cnt = int'(cpu_rst);
    q_cnt = int'(quiesce);
    d_cnt = int'(quiesce & ~cpu_rst);
    cnt   = 0;
    while (!done && cnt < BOUND) begin
      if (toggle) idle = ~idle;
      if (cnt + 1 == inject_at) begin
        req   = 1'b1;
        ibase = inj_base;
      end
      tick;
      req = 1'b0;
      cnt++;
      r_cnt += int'(cpu_rst);
      q_cnt += int'(quiesce);
      d_cnt += int'(quiesce & ~cpu_rst);
    end
    if (cnt >= BOUND) check("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) tick;
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_quiesce", 32'(quiesce), 32'd0);
    check("rst_busy",    32'(busy),    32'd1);
    check("rst_done",    32'(done),    32'd0);
    check("rst_adr",     32'(boot_adr), 32'h0100);

    // Power-on sequence
    rst = 1'b0;
    run(0, 8'h00, 1'b0, n, rc, qc, dc);
    check("po_latency", 32'(n),  32'(RST_CYCLES));
    check("po_cpu_rst", 32'(rc), 32'(RST_CYCLES));
    check("po_quiesce", 32'(qc), 32'(RST_CYCLES - 1));
    check("po_done",    32'(done), 32'd1);
    check("po_adr",     32'(boot_adr), 32'h0100);
    tick;
    check("po_busy",    32'(busy), 32'd0);
    check("po_idle_rst", 32'(cpu_rst), 32'd0);

    // Request with CPU already idle
    request(8'h3C, 1'b1);
    check("req_busy",    32'(busy),     32'd1);
    check("req_quiesce", 32'(quiesce),  32'd1);
    check("req_adr",     32'(boot_adr), 32'h3C00);
    check("req_cpu_rst", 32'(cpu_rst),  32'(1 - D));
    run(0, 8'h00, 1'b0, n, rc, qc, dc);
    check("req_latency", 32'(n),  32'(D + RST_CYCLES));
    check("req_cpu_rst_cnt", 32'(rc), 32'(RST_CYCLES));
    check("req_quiesce_cnt", 32'(qc), 32'(D + RST_CYCLES));
    check("req_adr_done", 32'(boot_adr), 32'h3C00);
    tick;
    check("req_busy_end", 32'(busy), 32'd0);

    // Idle never asserted: drain timeout (drain build) or idle ignored
    request(8'hA5, 1'b0);
    run(0, 8'h00, bit'(D == 0), n, rc, qc, dc);
    check("to_latency",   32'(n),  32'(D * DRAIN_TIMEOUT + RST_CYCLES));
    check("to_drain_cnt", 32'(dc), 32'(D * DRAIN_TIMEOUT));
    check("to_quiesce",   32'(qc), 32'(D * DRAIN_TIMEOUT + RST_CYCLES));
    check("to_cpu_rst",   32'(rc), 32'(RST_CYCLES));
    tick;
    ibase = 8'hFF;
    tick;
    tick;
    check("adr_stable",   32'(boot_adr), 32'hA500);
    check("idle_quiesce", 32'(quiesce), 32'd0);

    // Second request at HOLD cycle 10 restarts the hold window
    request(8'h3C, 1'b1);
    run(D + 10, 8'h55, 1'b0, n, rc, qc, dc);
    check("ext_latency", 32'(n),  32'(D + 10 + RST_CYCLES));
    check("ext_cpu_rst", 32'(rc), 32'(10 + RST_CYCLES));
    check("ext_adr",     32'(boot_adr), 32'h5500);
    tick;

    // Asynchronous reset mid-HOLD
    request(8'h3C, 1'b1);
    repeat (D + 5) tick;
    check("ar_pre_adr",  32'(boot_adr), 32'h3C00);
    check("ar_pre_rst",  32'(cpu_rst),  32'd1);
    check("ar_pre_q",    32'(quiesce),  32'd1);
    #3 rst = 1'b1;
    #1;
    check("ar_cpu_rst",  32'(cpu_rst),  32'd1);
    check("ar_adr",      32'(boot_adr), 32'h0100);
    check("ar_quiesce",  32'(quiesce),  32'd0);
    check("ar_busy",     32'(busy),     32'd1);
    tick;
    rst = 1'b0;
    run(0, 8'h00, 1'b0, n, rc, qc, dc);
    check("ar_po_latency", 32'(n), 32'(RST_CYCLES));
    check("ar_po_adr",     32'(boot_adr), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/boot_reset_ctrl.md
# boot_reset_ctrl

CPU boot/reset sequencer that sits directly downstream of the 8-bit Wishbone GPIO core. It consumes the core's one-cycle instruction-base-change pulse and 8-bit instruction base. It quiesces the soft CPU, holds it in reset for a programmed number of cycles, and releases it with a latched 16-bit boot vector. It also performs the power-on reset sequence for the CPU.

## Interface
Parameters:
- RST_CYCLES, 16: cycles cpu_rst_o is held asserted in HOLD; legal range 1..255.
- DRAIN_TIMEOUT, 255: maximum cycles spent in DRAIN waiting for idle_i; legal range 1..255.

Ports:
- clk_i  in  1  system clock; all state updates on its rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_i  in  1  re-boot request pulse, driven from the GPIO core's rst_o; sampled on clk_i.
- ibase_i  in  8  instruction base, driven from the GPIO core's ibase.
- idle_i  in  1  CPU reports bus idle / safe to reset.
- quiesce_o  out  1  request that the CPU stop issuing bus cycles.
- cpu_rst_o  out  1  CPU reset, active-high.
- boot_adr_o  out  16  boot vector = {latched ibase, 8'h00}.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the CPU is released.

## Operation
- All outputs are registered.
- Reset values while rst_i = 1:
  - state = HOLD, counter = 0.
  - cpu_rst_o = 1, quiesce_o = 0, busy_o = 1, done_o = 0.
  - boot_adr_o = 16'h0100, matching the GPIO core's ibase reset value of 8'h01.
- Because of the HOLD reset state, deasserting rst_i runs a full power-on HOLD→RELEASE→IDLE sequence with no request needed.
- States:
  - IDLE: all control outputs 0. On req_i = 1, latch boot_adr_o <= {ibase_i, 8'h00} and go to DRAIN (or HOLD if DRAIN is compiled out). Clear the counter.
  - DRAIN: quiesce_o = 1, busy_o = 1. Go to HOLD when idle_i = 1 is sampled, or when counter == DRAIN_TIMEOUT-1 (timeout). The counter increments each cycle in DRAIN and clears on exit.
  - HOLD: cpu_rst_o = 1, quiesce_o = 1. The counter increments each cycle. Go to RELEASE when counter == RST_CYCLES-1.
  - RELEASE: exactly one cycle. cpu_rst_o = 0, quiesce_o = 0, done_o = 1, busy_o = 1. Then go to IDLE.
- Counter: 8 bits, unsigned; it never wraps in legal configurations.
- req_i during DRAIN: re-latch boot_adr_o from ibase_i. The DRAIN timer is not restarted.
- req_i during HOLD: re-latch boot_adr_o and clear the counter, so HOLD lasts a fresh RST_CYCLES cycles from the following cycle.
- req_i during RELEASE: re-latch boot_adr_o and go to DRAIN (or HOLD) instead of IDLE. done_o still pulses in that cycle.
- idle_i is ignored outside DRAIN.
- boot_adr_o is stable from the cycle after the latch until the next accepted req_i. It is never updated by ibase_i changes without req_i.
- Reset mid-operation: asynchronous return to the reset values above. Any latched ibase is discarded (boot_adr_o = 16'h0100).

## Timing
- Request accepted at edge T (req_i = 1, IDLE): at T+1, state = DRAIN, quiesce_o = 1, busy_o = 1, and boot_adr_o holds the new value.
- DRAIN with idle_i already high: idle_i is sampled at T+1, and HOLD (cpu_rst_o = 1) starts at T+2.
- DRAIN timeout with idle_i = 0: DRAIN lasts exactly DRAIN_TIMEOUT cycles.
- HOLD lasts exactly RST_CYCLES cycles, followed by 1 RELEASE cycle, then IDLE.
- Best-case total latency from req_i to done_o is 1 + 1 + RST_CYCLES cycles.
- Power-on: first rising edge after rst_i falls counts as HOLD cycle 1. done_o fires RST_CYCLES edges after rst_i deassertion.

## Configuration
- BOOT_RESET_DRAIN_EN:
  - Defined: the DRAIN state, quiesce handshake and timeout counter are built as above.
  - Undefined: DRAIN does not exist. IDLE goes directly to HOLD on req_i. idle_i is unused. quiesce_o is still driven high in HOLD, and driven 0 in every other state, including the states where it would otherwise have been high in DRAIN.

## Test plan
- Power-on (RST_CYCLES = 16): pulse rst_i, release → cpu_rst_o = 1 for 16 edges, done_o pulse on edge 16, boot_adr_o = 16'h0100, then busy_o = 0.
- ibase_i = 8'h3C, req_i pulse, idle_i = 1 → DRAIN for 1 cycle, cpu_rst_o high 16 cycles, done_o, boot_adr_o = 16'h3C00.
- idle_i held 0, DRAIN_TIMEOUT = 8 → quiesce_o high exactly 8 cycles in DRAIN, then HOLD proceeds normally.
- Second req_i with ibase_i = 8'h55 at HOLD cycle 10 → HOLD extends to 10 + 16 cycles total, boot_adr_o = 16'h5500.
- rst_i asserted mid-HOLD after an 8'h3C request, asynchronous to clk_i → cpu_rst_o = 1 and boot_adr_o = 16'h0100 immediately, without waiting for a clock edge.
- Build without BOOT_RESET_DRAIN_EN: req_i at T → cpu_rst_o = 1 at T+1, idle_i toggling has no effect.
